// File: rtl/atm_session_engine.sv
// atm_session_engine
//
// Multi-account ATM session controller. Holds an account table (ID, PIN,
// balance, lock, wrong-PIN counter) in registers. The table is loaded through a
// programming port while idle. A card/PIN pair opens a session after
// authentication. The session then runs balance, withdraw, deposit and transfer
// commands over a valid/ready handshake until the card is ejected.
//
// Ports
//   Clock, Reset                  rising-edge clock, synchronous active-high reset
//   ProgValid/ProgIndex/ProgId/ProgPin/ProgBal
//                                 table entry write, accepted only in IDLE
//   CardValid/CardId/CardPin      credentials, accepted only in IDLE
//   CmdValid/CmdReady             command handshake (CmdReady high only in MENU)
//   CmdOp/CmdAmount/CmdDestId     0 BALANCE, 1 WITHDRAW, 2 DEPOSIT, 3 TRANSFER
//   Eject                         ends the session from MENU, produces no response
//   RespValid/Status/Balance      one-cycle result pulse, two cycles after acceptance
//   SessionActive                 high in MENU/EXEC
//
// Configuration macro: ATM_WITHDRAW_LIMIT_EN enables a per-session cap of
// WD_LIMIT on withdrawn money. Transfers count as withdrawals. Exceeding the
// cap gives ERR_LIMIT.

module atm_session_engine #(
    parameter int NUM_ACCOUNTS = 10,
    parameter int ID_W         = 8,
    parameter int PIN_W        = 8,
    parameter int BAL_W        = 16,
    parameter int MAX_TRIES    = 3,
    parameter int WD_LIMIT     = 500
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic                            ProgValid,
    input  logic [$clog2(NUM_ACCOUNTS)-1:0] ProgIndex,
    input  logic [ID_W-1:0]                 ProgId,
    input  logic [PIN_W-1:0]                ProgPin,
    input  logic [BAL_W-1:0]                ProgBal,
    input  logic                            CardValid,
    input  logic [ID_W-1:0]                 CardId,
    input  logic [PIN_W-1:0]                CardPin,
    input  logic                            CmdValid,
    output logic                            CmdReady,
    input  logic [1:0]                      CmdOp,
    input  logic [BAL_W-1:0]                CmdAmount,
    input  logic [ID_W-1:0]                 CmdDestId,
    input  logic                            Eject,
    output logic                            RespValid,
    output logic [2:0]                      Status,
    output logic [BAL_W-1:0]                Balance,
    output logic                            SessionActive
);

    localparam int IDX_W = $clog2(NUM_ACCOUNTS);

    localparam logic [2:0] ST_OK         = 3'd0;
    localparam logic [2:0] ST_ERR_ID     = 3'd1;
    localparam logic [2:0] ST_ERR_PIN    = 3'd2;
    localparam logic [2:0] ST_ERR_LOCKED = 3'd3;
    localparam logic [2:0] ST_ERR_FUNDS  = 3'd4;
    localparam logic [2:0] ST_ERR_OVF    = 3'd5;
    localparam logic [2:0] ST_ERR_DEST   = 3'd6;
    localparam logic [2:0] ST_ERR_LIMIT  = 3'd7;

    localparam logic [1:0] OP_BALANCE  = 2'd0;
    localparam logic [1:0] OP_WITHDRAW = 2'd1;
    localparam logic [1:0] OP_DEPOSIT  = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_AUTH, S_MENU, S_EXEC} state_t;
    state_t state, state_nxt;

    logic [ID_W-1:0]  ent_id    [NUM_ACCOUNTS];
    logic [PIN_W-1:0] ent_pin   [NUM_ACCOUNTS];
    logic [BAL_W-1:0] ent_bal   [NUM_ACCOUNTS];
    logic             ent_valid [NUM_ACCOUNTS];
    logic             ent_lock  [NUM_ACCOUNTS];
    logic [3:0]       ent_tries [NUM_ACCOUNTS];

    logic [ID_W-1:0]  card_id_q;
    logic [PIN_W-1:0] card_pin_q;
    logic [1:0]       op_q;
    logic [BAL_W-1:0] amt_q;
    logic [ID_W-1:0]  dest_q;
    logic [IDX_W-1:0] sess_idx;

    // Results are staged once before reaching the outputs, which gives the
    // fixed two-cycle latency from acceptance to RespValid.
    logic             pend_valid;
    logic [2:0]       pend_status;
    logic [BAL_W-1:0] pend_bal;

    logic             card_hit, dest_hit;
    logic [IDX_W-1:0] card_idx, dest_idx;
    logic             auth_ok, lock_now;
    logic [2:0]       auth_status;
    logic [3:0]       tries_inc;
    logic [BAL_W-1:0] cur_bal, dst_bal, new_own, new_dst;
    logic [BAL_W:0]   own_sum, dst_sum;
    logic             short_funds, limit_hit, do_dst, wd_count_en;
    logic [2:0]       exec_status;
    logic             prog_in_range;

`ifdef ATM_WITHDRAW_LIMIT_EN
    logic [BAL_W:0]   wd_total;
    logic [BAL_W+1:0] wd_next;
`else
    logic             unused_cfg;
    assign unused_cfg = (WD_LIMIT != 0) ^ wd_count_en;
`endif

    assign prog_in_range = int'(ProgIndex) < NUM_ACCOUNTS;

    // Descending scan so the lowest matching valid index wins.
    always_comb begin
        card_hit = 1'b0;
        card_idx = '0;
        dest_hit = 1'b0;
        dest_idx = '0;
        for (int i = NUM_ACCOUNTS - 1; i >= 0; i--) begin
            if (ent_valid[i] && ent_id[i] == card_id_q) begin
                card_hit = 1'b1;
                card_idx = IDX_W'(i);
            end
            if (ent_valid[i] && ent_id[i] == dest_q) begin
                dest_hit = 1'b1;
                dest_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        auth_ok     = 1'b0;
        auth_status = ST_ERR_ID;
        tries_inc   = ent_tries[card_idx] + 4'd1;
        lock_now    = tries_inc >= 4'(MAX_TRIES);
        if (!card_hit) begin
            auth_status = ST_ERR_ID;
        end else if (ent_lock[card_idx]) begin
            auth_status = ST_ERR_LOCKED;
        end else if (ent_pin[card_idx] == card_pin_q) begin
            auth_status = ST_OK;
            auth_ok     = 1'b1;
        end else begin
            auth_status = lock_now ? ST_ERR_LOCKED : ST_ERR_PIN;
        end
    end

    // Sums are one bit wider than a balance, so an overflow is seen before
    // anything wraps into the table.
    always_comb begin
        cur_bal     = ent_bal[sess_idx];
        dst_bal     = ent_bal[dest_idx];
        own_sum     = {1'b0, cur_bal} + {1'b0, amt_q};
        dst_sum     = {1'b0, dst_bal} + {1'b0, amt_q};
        short_funds = amt_q > cur_bal;
`ifdef ATM_WITHDRAW_LIMIT_EN
        wd_next     = {1'b0, wd_total} + {2'b00, amt_q};
        limit_hit   = wd_next > (BAL_W+2)'(WD_LIMIT);
`else
        limit_hit   = 1'b0;
`endif
        exec_status = ST_OK;
        new_own     = cur_bal;
        new_dst     = dst_bal;
        do_dst      = 1'b0;
        wd_count_en = 1'b0;
        case (op_q)
            OP_BALANCE: exec_status = ST_OK;
            OP_WITHDRAW: begin
                if (short_funds) begin
                    exec_status = ST_ERR_FUNDS;
                end else if (limit_hit) begin
                    exec_status = ST_ERR_LIMIT;
                end else begin
                    new_own     = cur_bal - amt_q;
                    wd_count_en = 1'b1;
                end
            end
            OP_DEPOSIT: begin
                if (own_sum[BAL_W]) exec_status = ST_ERR_OVF;
                else                new_own     = own_sum[BAL_W-1:0];
            end
            default: begin
                if (!dest_hit || dest_idx == sess_idx) begin
                    exec_status = ST_ERR_DEST;
                end else if (short_funds) begin
                    exec_status = ST_ERR_FUNDS;
                end else if (limit_hit) begin
                    exec_status = ST_ERR_LIMIT;
                end else if (dst_sum[BAL_W]) begin
                    exec_status = ST_ERR_OVF;
                end else begin
                    new_own     = cur_bal - amt_q;
                    new_dst     = dst_sum[BAL_W-1:0];
                    do_dst      = 1'b1;
                    wd_count_en = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Eject beats CmdValid in MENU.
    always_comb begin
        state_nxt     = state;
        CmdReady      = 1'b0;
        SessionActive = 1'b0;
        case (state)
            S_IDLE: if (CardValid) state_nxt = S_AUTH;
            S_AUTH: state_nxt = auth_ok ? S_MENU : S_IDLE;
            S_MENU: begin
                CmdReady      = 1'b1;
                SessionActive = 1'b1;
                if (Eject)         state_nxt = S_IDLE;
                else if (CmdValid) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                SessionActive = 1'b1;
                state_nxt     = S_MENU;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                ent_id[i]    <= '0;
                ent_pin[i]   <= '0;
                ent_bal[i]   <= '0;
                ent_valid[i] <= 1'b0;
                ent_lock[i]  <= 1'b0;
                ent_tries[i] <= '0;
            end
            card_id_q   <= '0;
            card_pin_q  <= '0;
            op_q        <= '0;
            amt_q       <= '0;
            dest_q      <= '0;
            sess_idx    <= '0;
            pend_valid  <= 1'b0;
            pend_status <= '0;
            pend_bal    <= '0;
            RespValid   <= 1'b0;
            Status      <= '0;
            Balance     <= '0;
`ifdef ATM_WITHDRAW_LIMIT_EN
            wd_total    <= '0;
`endif
        end else begin
            pend_valid <= 1'b0;
            RespValid  <= pend_valid;
            if (pend_valid) begin
                Status  <= pend_status;
                Balance <= pend_bal;
            end
            case (state)
                S_IDLE: begin
                    if (ProgValid && prog_in_range) begin
                        ent_id[ProgIndex]    <= ProgId;
                        ent_pin[ProgIndex]   <= ProgPin;
                        ent_bal[ProgIndex]   <= ProgBal;
                        ent_valid[ProgIndex] <= 1'b1;
                        ent_lock[ProgIndex]  <= 1'b0;
                        ent_tries[ProgIndex] <= '0;
                    end
                    if (CardValid) begin
                        card_id_q  <= CardId;
                        card_pin_q <= CardPin;
                    end
                end
                S_AUTH: begin
                    pend_valid  <= 1'b1;
                    pend_status <= auth_status;
                    pend_bal    <= '0;
                    // A locked account keeps its counter frozen.
                    if (card_hit && !ent_lock[card_idx]) begin
                        if (auth_ok) begin
                            ent_tries[card_idx] <= '0;
                        end else begin
                            ent_tries[card_idx] <= tries_inc;
                            ent_lock[card_idx]  <= lock_now;
                        end
                    end
                    if (auth_ok) begin
                        sess_idx <= card_idx;
`ifdef ATM_WITHDRAW_LIMIT_EN
                        wd_total <= '0;
`endif
                    end
                end
                S_MENU: begin
                    if (CmdValid && !Eject) begin
                        op_q   <= CmdOp;
                        amt_q  <= CmdAmount;
                        dest_q <= CmdDestId;
                    end
                end
                S_EXEC: begin
                    pend_valid        <= 1'b1;
                    pend_status       <= exec_status;
                    pend_bal          <= new_own;
                    ent_bal[sess_idx] <= new_own;
                    if (do_dst) ent_bal[dest_idx] <= new_dst;
`ifdef ATM_WITHDRAW_LIMIT_EN
                    if (wd_count_en) wd_total <= wd_next[BAL_W:0];
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
